// File: rtl/key_expansion_pkg.sv
// Shared AES-128 key-schedule constants, FSM state type and round-constant table.
package key_expansion_pkg;

    localparam int KEY_S = 128;
    localparam int BLK_S = 128;
    localparam int Nr    = 10;
    localparam int Nk    = 4;

    typedef enum logic [1:0] {
        KE_IDLE   = 2'd0,
        KE_EXPAND = 2'd1,
        KE_DONE   = 2'd2
    } ke_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Load/status/read-port bundle between the key schedule and its user (cipher or bench).
interface key_expansion_if;
    import key_expansion_pkg::*;

    logic [0:KEY_S-1] key_in;
    logic             key_valid;
    logic             busy;
    logic             done;
    logic             keys_ready;
    logic             r_e;
    logic [0:3]       round_no;
    logic [0:KEY_S-1] key;

    modport master (
        output key_in, key_valid, r_e, round_no,
        input  busy, done, keys_ready, key
    );

    modport slave (
        input  key_in, key_valid, r_e, round_no,
        output busy, done, keys_ready, key
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, 8-bit in / 8-bit out; shared with cipher SubBytes.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits at the left (lowest ascending index) of the table.
    assign out_byte = SBOX_TABLE[{in_byte, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: expands one round key per cycle into rk[0:Nr] and serves
// registered single-cycle reads to the cipher stage.
module key_expansion
    import key_expansion_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    key_expansion_if.slave  kif
);

    ke_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             keys_ready_q, keys_ready_d;
    logic [0:KEY_S-1] key_q, key_d;
    logic [0:KEY_S-1] rk_q [0:Nr];
    logic [0:KEY_S-1] rk_d [0:Nr];

    logic [0:KEY_S-1] prev_rk;
    logic [0:KEY_S-1] new_rk;
    logic [31:0]      last_w;
    logic [31:0]      rot_w;
    logic [31:0]      sub_w;

    function automatic logic [0:KEY_S-1] next_round_key(
        input logic [0:KEY_S-1] prev,
        input logic [31:0]      sub_rot,
        input logic [7:0]       rc
    );
        logic [31:0] w0, w1, w2, w3;
        w0 = prev[0:31]   ^ sub_rot ^ {rc, 24'h0};
        w1 = prev[32:63]  ^ w0;
        w2 = prev[64:95]  ^ w1;
        w3 = prev[96:127] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // rk[cnt-1] is always the most recently written round key while expanding.
    always_comb begin
        prev_rk = '0;
        for (int i = 0; i < Nr; i++) begin
            if (cnt_q == 4'(i + 1)) prev_rk = rk_q[i];
        end
    end

    assign last_w = prev_rk[96:127];
    assign rot_w  = {last_w[23:0], last_w[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*g +: 8]),
            .out_byte (sub_w[8*g +: 8])
        );
    end

    assign new_rk = next_round_key(prev_rk, sub_w, rcon(cnt_q));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        keys_ready_d = keys_ready_q;
        rk_d         = rk_q;
        case (state_q)
            KE_IDLE: begin
                if (kif.key_valid) begin
                    rk_d[0]      = kif.key_in;
                    cnt_d        = 4'd1;
                    keys_ready_d = 1'b0;
                    state_d      = KE_EXPAND;
                end
            end
            KE_EXPAND: begin
                for (int i = 1; i <= Nr; i++) begin
                    if (cnt_q == 4'(i)) rk_d[i] = new_rk;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(Nr)) begin
                    keys_ready_d = 1'b1;
                    state_d      = KE_DONE;
                end
            end
            KE_DONE: state_d = KE_IDLE;
            default: state_d = KE_IDLE;
        endcase
    end

    // Out-of-range indices and reads during expansion return zero.
    always_comb begin
        key_d = key_q;
        if (kif.r_e) begin
            key_d = '0;
            if (keys_ready_q) begin
                for (int i = 0; i <= Nr; i++) begin
                    if (kif.round_no == 4'(i)) key_d = rk_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= KE_IDLE;
            cnt_q        <= 4'd0;
            keys_ready_q <= 1'b0;
            key_q        <= '0;
            for (int i = 0; i <= Nr; i++) rk_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            keys_ready_q <= keys_ready_d;
            key_q        <= key_d;
            rk_q         <= rk_d;
        end
    end

    assign kif.busy       = (state_q == KE_EXPAND);
    assign kif.done       = (state_q == KE_DONE);
    assign kif.keys_ready = keys_ready_q;
    assign kif.key        = key_q;

endmodule

// File: tb/tb_key_expansion.sv
// Directed + random bench for key_expansion against a word-level AES-128 key schedule model.
module tb_key_expansion;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_expansion_if kif ();

    key_expansion dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb  [0:255];
    logic [127:0] mdl [0:10];

    localparam logic [127:0] KEY_KF  = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] KEY_STD = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic hi;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv, bx;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            bx = 8'(x);
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        kif.key_in    = k;
        kif.key_valid = 1'b1;
        tick();
        kif.key_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (kif.done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check(tag, 128'(kif.done), 128'h1);
        tick();
    endtask

    task automatic read_round(input int r);
        kif.r_e      = 1'b1;
        kif.round_no = 4'(r);
        tick();
        kif.r_e      = 1'b0;
    endtask

    task automatic sweep(input string tag);
        kif.r_e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            kif.round_no = 4'(i);
            tick();
            check($sformatf("%s_r%0d", tag, i), kif.key, (i <= 10) ? mdl[i] : 128'h0);
        end
        kif.r_e = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy;
        logic [127:0] rkey;

        kif.key_in    = '0;
        kif.key_valid = 1'b0;
        kif.r_e       = 1'b0;
        kif.round_no  = '0;
        build_sbox();

        #1 reset = 1'b0;
        #2;
        check("rst_busy",  128'(kif.busy), 128'h0);
        check("rst_done",  128'(kif.done), 128'h0);
        check("rst_ready", 128'(kif.keys_ready), 128'h0);
        check("rst_key",   kif.key, 128'h0);
        tick();
        tick();
        reset = 1'b1;
        read_round(0);
        check("rst_read0", kif.key, 128'h0);

        // Kung Fu key: timing window and known vectors
        expand_model(KEY_KF);
        start_key(KEY_KF);
        check("kf_ready_low", 128'(kif.keys_ready), 128'h0);
        nbusy = 0;
        for (int c = 0; c < 10; c++) begin
            if (kif.busy === 1'b1 && kif.done === 1'b0) nbusy++;
            tick();
        end
        check("kf_busy_cycles", 128'(nbusy), 128'd10);
        check("kf_done_hi",  128'(kif.done), 128'h1);
        check("kf_busy_lo",  128'(kif.busy), 128'h0);
        check("kf_ready_hi", 128'(kif.keys_ready), 128'h1);
        tick();
        check("kf_done_pulse", 128'(kif.done), 128'h0);
        read_round(1);
        check("kf_r1_const", kif.key, 128'he232fcf191129188b159e4e6d679a293);
        read_round(10);
        check("kf_r10_const", kif.key, 128'h28fddef86da4244accc0a4fe3b316f26);
        check("kf_r10_model", kif.key, mdl[10]);
        kif.r_e = 1'b0;
        tick();
        check("kf_hold", kif.key, mdl[10]);
        sweep("kf");

        // Restart with a new key; busy reads and a second key_valid are ignored
        expand_model(KEY_STD);
        start_key(KEY_STD);
        check("std_ready_low", 128'(kif.keys_ready), 128'h0);
        read_round(3);
        check("std_busy_read", kif.key, 128'h0);
        start_key(KEY_KF);
        wait_done("std_done");
        read_round(0);
        check("std_r0", kif.key, KEY_STD);
        read_round(10);
        check("std_r10", kif.key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sweep("std");

        // Random keys against the model
        for (int t = 0; t < 3; t++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            expand_model(rkey);
            start_key(rkey);
            wait_done($sformatf("rnd%0d_done", t));
            sweep($sformatf("rnd%0d", t));
        end

        // Reset in the middle of expansion
        start_key(KEY_KF);
        for (int c = 0; c < 4; c++) tick();
        reset = 1'b0;
        #2;
        check("mid_rst_busy",  128'(kif.busy), 128'h0);
        check("mid_rst_ready", 128'(kif.keys_ready), 128'h0);
        tick();
        reset = 1'b1;
        tick();
        read_round(0);
        check("mid_rst_read0", kif.key, 128'h0);
        check("mid_rst_ready2", 128'(kif.keys_ready), 128'h0);
        expand_model(KEY_KF);
        start_key(KEY_KF);
        wait_done("reload_done");
        sweep("reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
# key_expansion

Generates the eleven AES-128 round keys from a 128-bit cipher key and serves them to the `cipher` stage through its key-read port. `cipher` drives `r_e` and `round_no`; this block answers with the round key one cycle later. It replaces the behavioural key SRAM model used around `cipher` today. Expansion runs one full round key per cycle and needs no software involvement.

## Interface
Parameters (all from `aes.vh`; no module parameters):
- `KEY_S`, 128: key and round-key width.
- `Nr`, 10: number of rounds; round keys 0..`Nr` are stored.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `key_in`  in  [0:`KEY_S`-1]  cipher key; bit 0 is the MSB, word 0 is bits [0:31].
- `key_valid`  in  1  start pulse; `key_in` is sampled when this is 1 at a rising edge.
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when round key `Nr` has been written.
- `keys_ready`  out  1  stored schedule is complete and readable.
- `r_e`  in  1  read enable from `cipher`.
- `round_no`  in  [0:3]  round-key index from `cipher`.
- `key`  out  [0:`KEY_S`-1]  registered round key to `cipher`.

## Operation
- Storage: `rk[0:Nr]`, 11 x 128-bit registers. Internal counter `cnt` is 4 bits.
- The FSM has three states: IDLE, EXPAND, DONE.
- **IDLE**:
  - On `key_valid`=1: `rk[0]` <= `key_in`, `cnt` <= 1, `keys_ready` <= 0, go to EXPAND.
  - Otherwise hold state.
- **EXPAND**, each cycle:
  - `rk[cnt]` <= f(`rk[cnt-1]`, `Rcon[cnt]`), then `cnt`++.
  - f: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - When `cnt`=`Nr`: go to DONE.
- **DONE**: lasts exactly one cycle, then returns to IDLE.
  - `done`=1 and `busy`=0 during DONE.
  - `keys_ready` <= 1 on entry.
- `busy` is 1 in EXPAND only.
- Read path, on each rising edge with `r_e`=1:
  - `key` <= `rk[round_no]` if `keys_ready`=1 and `round_no`<=`Nr`.
  - Otherwise `key` <= 0.
- With `r_e`=0, `key` holds its value.
- Boundary behaviour:
  - `key_valid` in EXPAND or DONE is ignored; there is no queuing.
  - `key_valid` in IDLE with `keys_ready`=1 restarts expansion. Old keys become unreadable immediately: `keys_ready` goes 0 on the same edge.
  - Reads issued while `busy`=1 return 0.
  - `round_no` values 11..15 return 0.
  - Reset asserted mid-expansion aborts immediately. After deassertion the block is in IDLE with `keys_ready`=0, and the schedule must be reloaded.
- Reset values:
  - `busy`=0, `done`=0, `keys_ready`=0, `key`=0.
  - State IDLE, `cnt`=0.
  - `rk[*]`=0.

## Timing
- `key_valid` sampled at edge N:
  - `rk[0]` is written at N.
  - `rk[1]`..`rk[10]` are written at edges N+1..N+10.
  - State is DONE after N+10: `done` is high for the cycle between N+10 and N+11, and `keys_ready`=1 from N+10.
  - Back in IDLE after N+11.
- Read latency is 1 cycle. `r_e` with `round_no` sampled at edge M gives a valid `key` after M. This matches `cipher`'s expectation that `key` is stable at the next edge.
- `cipher` may issue a read every cycle; there are no bubbles.
- Critical path per cycle: four S-box lookups plus a 3-deep XOR chain. Single-cycle at the target clock is required.

## Structure
- `aes.vh` holds `KEY_S`, `BLK_S`, `Nr`, `Nk`, and the `Rcon[1:10]` constants (01,02,04,08,10,20,40,80,1b,36). It also holds the FSM state encodings `KE_IDLE`, `KE_EXPAND`, `KE_DONE`.
- Sub-module `aes_sbox`: combinational, 8-bit in and 8-bit out, instantiated 4x for SubWord. It is shared with `cipher`'s SubBytes.
- The RotWord/SubWord/XOR step is a function in this module and is not a separate module.

## Test plan
- Key 5468617473206d79204b756e67204675, pulse `key_valid`:
  - Within the 11-cycle window, `busy` high for 10 cycles, then `done` high for 1 cycle.
  - Reading round 1 gives e232fcf191129188b159e4e6d679a293.
  - Reading round 10 gives 28fddef86da4244accc0a4fe3b316f26.
- Key 2b7e151628aed2a6abf7158809cf4f3c:
  - Round 0 returns the key itself.
  - Round 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- Sweep `round_no` 0..15 with `r_e`=1 on consecutive cycles after `done`:
  - Each `key` appears one cycle after its request.
  - Indices 11..15 return 0.
- Read round 3 while `busy`=1 → `key`=0.
- Pulse `key_valid` with a different key while `busy`=1 → ignored; the schedule matches the first key.
- Assert `reset`=0 at cycle 5 of expansion, release, then read round 0 → `key`=0 and `keys_ready`=0. A reload then produces the correct schedule.
- Connect to `cipher` with plaintext 54776F204F6E65204E696E652054776F and the Kung Fu key → `ciphertext`=29c3505f571420f6402299b31a02d73a.
